iob_sp_ram_be_arb: RTL and testbench
====================================

// Module: iob_sp_ram_be_arb
// PURPOSE
//  Round-robin arbiter/controller that shares one single-port, byte-write-enable,
//  read-first RAM (1-cycle read latency) between N_REQ native valid/ready requesters.
//  Grants at most one access per cycle and returns read data one cycle after accept.
//  Optionally sequences a post-reset zero-fill of the whole RAM before accepting traffic.
// PARAMETERS
//  N_REQ       2                   number of requesters (>=2)
//  ADDR_W      10                  RAM address width; depth = 2**ADDR_W
//  DATA_W      32                  RAM data width; multiple of 8
//  STRB_W      DATA_W/8            byte enables per word (localparam)
// PORTS
//  clk         in   1              clock
//  rst         in   1              synchronous reset, active-high
//  req_valid   in   N_REQ          request valid, one bit per requester
//  req_addr    in   N_REQ*ADDR_W   word address, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata   in   N_REQ*DATA_W   write data, packed as req_addr
//  req_wstrb   in   N_REQ*STRB_W   byte enables; all zero = read
//  req_ready   out  N_REQ          request accepted this cycle (one-hot or zero)
//  resp_valid  out  N_REQ          read data valid for requester i (one-hot or zero)
//  resp_rdata  out  DATA_W         read data, shared by all requesters
//  init_done   out  1              1 = arbiter accepting requests
//  ram_en      out  1              RAM enable
//  ram_we      out  STRB_W         RAM byte write enables
//  ram_addr    out  ADDR_W         RAM address
//  ram_din     out  DATA_W         RAM write data
//  ram_dout    in   DATA_W         RAM read data (registered in the RAM)
// BEHAVIOUR
//  - FSM states: INIT (zero-fill sweep), RUN. Reset -> INIT if IOB_SP_RAM_ARB_CLR_EN, else RUN.
//  - Reset values: req_ready=0, resp_valid=0, resp_rdata=ram_dout (pass-through),
//    init_done=0 (CLR_EN) / 1, ram_en=0, ram_we=0; last_gnt=N_REQ-1 (so req 0 wins first).
//  - RUN: combinational grant g = first i with req_valid[i] set, scanning from last_gnt+1
//    modulo N_REQ. If any valid: ram_en=1, ram_addr/ram_din/ram_we = requester g fields,
//    req_ready[g]=1 same cycle; last_gnt<=g at clock edge. No valid: ram_en=0, last_gnt holds.
//  - Requester holds valid/addr/wdata/wstrb stable until ready; deasserting early is illegal.
//  - Read (wstrb==0) accepted in cycle T: resp_valid[g]=1 in T+1, resp_rdata=ram_dout in T+1.
//    Writes get no response; req_ready is the completion. Back-to-back: 1 access per cycle.
//  - Read-after-write same address, consecutive cycles: read returns written data.
//  - Partial wstrb: only enabled bytes change; RAM old-data output on writes is ignored.
//  - Single requester always valid: granted every cycle (round-robin never starves others).
//  - INIT: counter cnt from 0; each cycle ram_en=1, ram_we=all ones, ram_din=0, ram_addr=cnt;
//    req_ready=0. At cnt=2**ADDR_W-1 -> RUN, init_done<=1 next cycle. Sweep = 2**ADDR_W cycles.
//  - rst mid-INIT restarts sweep at 0. rst mid-RUN drops in-flight read (resp_valid=0 next
//    cycle); RAM contents are not restored.
// CONFIGURATION
//  IOB_SP_RAM_ARB_CLR_EN defined: INIT zero-fill after every reset, init_done rises
//    2**ADDR_W+1 cycles after rst falls. Undefined: no INIT state, no counter,
//    init_done tied 1, requests granted in first cycle after reset; RAM contents keep
//    the RAM init file.
// STRUCTURE
//  - Package iob_sp_ram_arb_pkg: FSM state encoding (INIT, RUN), STRB_W helper,
//    idx width function clog2(N_REQ).
//  - One sub-module: iob_rr_arb (N_REQ req -> one-hot gnt + index, last_gnt register,
//    en input to advance pointer). Datapath mux and FSM in top.
// TESTING (bench uses behavioural 1-cycle read-first byte-enable RAM model)
//  - CLR_EN, ADDR_W=4: release rst -> ram_we=4'hF, addr 0..15, din 0 for 16 cycles;
//    init_done=1 at cycle 17; reads of addr 5 return 0.
//  - Req0 write addr 3 = 32'hDEADBEEF wstrb F, next cycle read addr 3 -> resp_valid[0] and
//    resp_rdata=32'hDEADBEEF one cycle after ready.
//  - Byte strobe: write 32'h11223344 then wstrb 4'b0010 data 32'hxxxxAAxx -> read 32'h1122AA44.
//  - Both requesters valid continuously, 8 cycles -> grants 0,1,0,1,0,1,0,1; each read
//    response tagged to correct requester.
//  - Only req1 valid for 4 cycles -> ready[1] every cycle, ready[0] never.
//  - Assert rst with read in flight -> resp_valid stays 0 next cycle; CLR_EN sweep restarts at 0.

Source files
------------

// File: rtl/iob_sp_ram_arb_pkg.sv
// Shared types and sizing helpers for the byte-enable single-port RAM arbiter.
package iob_sp_ram_arb_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int idx_w(input int n_req);
    return (n_req <= 1) ? 1 : $clog2(n_req);
  endfunction

endpackage

// File: rtl/iob_rr_arb.sv
// Round-robin arbiter: one-hot grant plus index, scanning from the requester after the last winner.
module iob_rr_arb
  import iob_sp_ram_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic [IDX_W-1:0] last_r;
  logic [IDX_W-1:0] cand_s;
  logic             hit_s;

  // Priority scan starting one past the previous winner, wrapping modulo N_REQ.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    cand_s  = '0;
    hit_s   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_s       = IDX_W'((int'(last_r) + k) % N_REQ);
      hit_s        = !any && req[cand_s];
      any          = any | hit_s;
      gnt[cand_s]  = gnt[cand_s] | hit_s;
      gnt_idx      = hit_s ? cand_s : gnt_idx;
    end
  end

  // Last-winner pointer; starts at N_REQ-1 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= IDX_W'(N_REQ - 1);
    end else if (en && any) begin
      last_r <= gnt_idx;
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/iob_sp_ram_be_arb.sv
// Shares one read-first, byte-enable single-port RAM among N_REQ valid/ready requesters.
// Define IOB_SP_RAM_ARB_CLR_EN to zero-fill the whole RAM after every reset.
module iob_sp_ram_be_arb
  import iob_sp_ram_arb_pkg::*;
#(
  parameter  int N_REQ  = 2,
  parameter  int ADDR_W = 10,
  parameter  int DATA_W = 32,
  localparam int STRB_W = strb_w(DATA_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  input  logic [N_REQ*STRB_W-1:0] req_wstrb,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]       resp_rdata,
  output logic                    init_done,
  output logic                    ram_en,
  output logic [STRB_W-1:0]       ram_we,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       ram_din,
  input  logic [DATA_W-1:0]       ram_dout
);

  localparam int IDX_W = idx_w(N_REQ);

  logic [N_REQ-1:0]  gnt_s;
  logic [IDX_W-1:0]  gnt_idx_s;
  logic              any_s;
  logic              run_s;
  logic              init_s;
  logic [ADDR_W-1:0] init_addr_s;
  logic              init_done_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_din_s;
  logic [STRB_W-1:0] sel_we_s;
  logic [N_REQ-1:0]  resp_valid_r;

  iob_rr_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (run_s),
    .req     (req_valid),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s),
    .any     (any_s)
  );

`ifdef IOB_SP_RAM_ARB_CLR_EN
  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] cnt_r;
  logic              init_done_r;

  // State, sweep counter and init_done registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_INIT;
      cnt_r       <= '0;
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= (state_r == ST_INIT) ? cnt_r + 1'b1 : '0;
      init_done_r <= (state_nxt_s == ST_RUN);
    end
  end

  // Leave the sweep once the last address has been cleared.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (cnt_r == {ADDR_W{1'b1}}) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_INIT;
    endcase
  end

  assign run_s       = (state_r == ST_RUN) && !rst;
  assign init_s      = (state_r == ST_INIT) && !rst;
  assign init_addr_s = cnt_r;
  assign init_done_s = init_done_r;
`else
  assign run_s       = !rst;
  assign init_s      = 1'b0;
  assign init_addr_s = '0;
  assign init_done_s = 1'b1;
`endif

  // Select the winning requester's fields by index (AND-OR mux).
  always_comb begin
    sel_addr_s = '0;
    sel_din_s  = '0;
    sel_we_s   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_addr_s = sel_addr_s | ({ADDR_W{gnt_idx_s == IDX_W'(i)}} & req_addr[i*ADDR_W +: ADDR_W]);
      sel_din_s  = sel_din_s  | ({DATA_W{gnt_idx_s == IDX_W'(i)}} & req_wdata[i*DATA_W +: DATA_W]);
      sel_we_s   = sel_we_s   | ({STRB_W{gnt_idx_s == IDX_W'(i)}} & req_wstrb[i*STRB_W +: STRB_W]);
    end
  end

  // RAM port and same-cycle ready; the sweep owns the RAM while it runs.
  always_comb begin
    req_ready = '0;
    ram_en    = 1'b0;
    ram_we    = '0;
    ram_addr  = '0;
    ram_din   = '0;
    if (init_s) begin
      ram_en   = 1'b1;
      ram_we   = '1;
      ram_addr = init_addr_s;
      ram_din  = '0;
    end else if (run_s && any_s) begin
      ram_en    = 1'b1;
      ram_we    = sel_we_s;
      ram_addr  = sel_addr_s;
      ram_din   = sel_din_s;
      req_ready = gnt_s;
    end else begin
      ram_en = 1'b0;
    end
  end

  // Read responses are tagged one cycle after acceptance; writes get none.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_r <= '0;
    end else if (run_s && any_s && (sel_we_s == '0)) begin
      resp_valid_r <= gnt_s;
    end else begin
      resp_valid_r <= '0;
    end
  end

  assign resp_valid = resp_valid_r;
  assign resp_rdata = ram_dout;
  assign init_done  = init_done_s;

endmodule

// File: tb/tb_iob_sp_ram_be_arb.sv
// Bench for iob_sp_ram_be_arb: behavioural RAM, spec-level model checked every cycle, plus directed literals.
module tb_iob_sp_ram_be_arb;

  localparam int N     = 2;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int SW    = 4;
  localparam int DEPTH = 16;
`ifdef IOB_SP_RAM_ARB_CLR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_wstrb;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    resp_valid;
  logic [DW-1:0]   resp_rdata;
  logic            init_done;
  logic            ram_en;
  logic [SW-1:0]   ram_we;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_din;
  logic [DW-1:0]   ram_dout;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  iob_sp_ram_be_arb #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .init_done  (init_done),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  // Read-first byte-enable RAM with registered output
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_dout <= mem[ram_addr];
      for (int b = 0; b < SW; b++)
        if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory contents, pointer, sweep progress, pending read
  logic [DW-1:0] ref_mem [DEPTH];
  int            m_last = N - 1;
  bit            m_run  = !CLR;
  int            m_cnt  = 0;
  bit            m_pend = 1'b0;
  int            m_pid  = 0;
  logic [DW-1:0] m_pdata;
  bit            n_pend;
  int            n_pid;
  logic [DW-1:0] n_pdata;
  int            g;
  int            mc;
  logic [N-1:0]  e_ready;
  logic [N-1:0]  e_rv;
  logic          e_en;
  logic [SW-1:0] e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din;

  always @(negedge clk) begin
    if (chk_en) begin
      e_rv = '0;
      if (m_pend) e_rv[m_pid] = 1'b1;
      chk("resp_valid", 32'(resp_valid), 32'(e_rv));
      if (m_pend) chk("resp_rdata", resp_rdata, m_pdata);
      chk("init_done", 32'(init_done), 32'(m_run));

      e_ready = '0; e_en = 1'b0; e_we = '0; e_addr = '0; e_din = '0;
      n_pend = 1'b0; n_pid = 0; n_pdata = '0;
      if (rst) begin
        m_run = !CLR; m_cnt = 0; m_last = N - 1;
      end else if (!m_run) begin
        e_en = 1'b1; e_we = '1; e_addr = AW'(m_cnt); e_din = '0;
        ref_mem[m_cnt] = '0;
        if (m_cnt == DEPTH - 1) m_run = 1'b1;
        m_cnt++;
      end else begin
        g = -1;
        for (int k = 1; k <= N; k++) begin
          mc = (m_last + k) % N;
          if (g < 0 && req_valid[mc]) g = mc;
        end
        if (g >= 0) begin
          e_en = 1'b1;
          e_ready[g] = 1'b1;
          e_addr = req_addr[g*AW +: AW];
          e_din  = req_wdata[g*DW +: DW];
          e_we   = req_wstrb[g*SW +: SW];
          if (e_we == '0) begin
            n_pend = 1'b1; n_pid = g; n_pdata = ref_mem[e_addr];
          end else begin
            for (int b = 0; b < SW; b++)
              if (e_we[b]) ref_mem[e_addr][b*8 +: 8] = e_din[b*8 +: 8];
          end
          m_last = g;
        end
      end
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("ram_en", 32'(ram_en), 32'(e_en));
      chk("ram_we", 32'(ram_we), 32'(e_we));
      if (e_en) begin
        chk("ram_addr", 32'(ram_addr), 32'(e_addr));
        chk("ram_din", ram_din, e_din);
      end
      m_pend = n_pend; m_pid = n_pid; m_pdata = n_pdata;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_valid[i]         = v;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_wstrb[i*SW +: SW] = s;
  endtask

  // One accepted access by requester i, valid dropped afterwards
  task automatic acc(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [SW-1:0] s);
    logic [N-1:0] oh;
    oh = '0;
    oh[i] = 1'b1;
    set_req(i, 1'b1, a, d, s);
    @(negedge clk);
    chk("acc_ready", 32'(req_ready), 32'(oh));
    next_cycle();
    set_req(i, 1'b0, '0, '0, '0);
  endtask

  task automatic rsp(input int i, input logic [DW-1:0] exp);
    logic [N-1:0] oh;
    oh = '0;
    oh[i] = 1'b1;
    @(negedge clk);
    chk("rsp_valid", 32'(resp_valid), 32'(oh));
    chk("rsp_data", resp_rdata, exp);
    next_cycle();
  endtask

  task automatic wait_init();
    int n;
    n = 1;
    @(negedge clk);
    while (!init_done && n < 100) begin
      next_cycle();
      n++;
      @(negedge clk);
    end
    chk("init_done_cycle", 32'(n), CLR ? 32'd17 : 32'd1);
    next_cycle();
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 32'h5A00_0000 + 32'(i);
      ref_mem[i] = 32'h5A00_0000 + 32'(i);
    end
    next_cycle();
    chk_en = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_init_done", 32'(init_done), CLR ? 32'd0 : 32'd1);
      chk("rst_ram_en", 32'(ram_en), 32'd0);
      next_cycle();
    end
    rst = 1'b0;
    wait_init();

    acc(0, 4'd5, 32'd0, 4'h0);
    rsp(0, CLR ? 32'h0000_0000 : 32'h5A00_0005);

    acc(0, 4'd3, 32'hDEAD_BEEF, 4'hF);
    acc(0, 4'd3, 32'd0, 4'h0);
    rsp(0, 32'hDEAD_BEEF);

    acc(0, 4'd7, 32'h1122_3344, 4'hF);
    acc(0, 4'd7, 32'h5555_AA55, 4'b0010);
    acc(0, 4'd7, 32'd0, 4'h0);
    rsp(0, 32'h1122_AA44);

    set_req(1, 1'b1, 4'd5, 32'd0, 4'h0);
    repeat (4) begin
      @(negedge clk);
      chk("solo_ready", 32'(req_ready), 32'h2);
      next_cycle();
    end

    set_req(0, 1'b1, 4'd3, 32'd0, 4'h0);
    set_req(1, 1'b1, 4'd7, 32'd0, 4'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_ready", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k > 0) begin
        chk("rr_rv", 32'(resp_valid), (k % 2 == 1) ? 32'h1 : 32'h2);
        chk("rr_data", resp_rdata, (k % 2 == 1) ? 32'hDEAD_BEEF : 32'h1122_AA44);
      end
      next_cycle();
    end
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    rsp(1, 32'h1122_AA44);

    acc(1, 4'd9, 32'hCAFE_F00D, 4'hF);
    acc(0, 4'd9, 32'd0, 4'h0);
    rsp(0, 32'hCAFE_F00D);

    set_req(0, 1'b1, 4'd3, 32'd0, 4'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rd_ready", 32'(req_ready), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rst_rd_rv", 32'(resp_valid), 32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", 32'(req_ready), CLR ? 32'd0 : 32'd1);
    chk("rel_addr", 32'(ram_addr), CLR ? 32'd0 : 32'd3);
    chk("rel_we", 32'(ram_we), CLR ? 32'hF : 32'h0);
    repeat (4) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("restart_addr", 32'(ram_addr), CLR ? 32'd0 : 32'd3);
    chk("restart_en", 32'(ram_en), 32'd1);
    set_req(0, 1'b0, '0, '0, '0);
    next_cycle();
    repeat (CLR ? 16 : 1) next_cycle();
    acc(0, 4'd3, 32'd0, 4'h0);
    rsp(0, CLR ? 32'h0000_0000 : 32'hDEAD_BEEF);
    repeat (2) next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
